// File: rtl/uart_pkg.sv
// Shared UART definitions: data width, TX state encoding, UART CON bits.
// UART_TX_PARITY_EN adds the PARITY state (3-bit encoding).
package uart_pkg;

  localparam int UART_DATA_W = 8;

  localparam int TX_BUSY_BIT = 0;
  localparam int TX_DONE_BIT = 1;

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_e;
`else
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;
`endif

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period counter; bit_tick marks the last cycle of each bit.
// Shared by the TX and RX paths.
module uart_baud_gen #(
  parameter int CLKS_PER_BIT = 10417
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  output logic bit_tick
);

  localparam int CW = (CLKS_PER_BIT > 1) ?
                      $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      cnt_q <= '0;
    end else if (cnt_q == LAST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign bit_tick = (cnt_q == LAST) && !clr;

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter for the peripheral bus TXD register.
// Define UART_TX_PARITY_EN to append an even-parity bit (8E1).
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 10417
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [UART_DATA_W-1:0] tx_data,
  input  logic                   tx_start,
  output logic                   tx_busy,
  output logic                   tx_done,
  output logic                   tx
);

  uart_state_e            state_q, state_d;
  logic [UART_DATA_W-1:0] sh_q, sh_d;
  logic [2:0]             idx_q, idx_d;
  logic                   tx_q, tx_d;
  logic                   done_q, done_d;
  logic                   bit_tick;
`ifdef UART_TX_PARITY_EN
  logic                   par_q, par_d;
`endif

  // Counter held at zero while idle so each frame starts a fresh period
  uart_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk     (clk),
    .reset   (reset),
    .clr     (state_q == IDLE),
    .bit_tick(bit_tick)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      sh_q    <= '0;
      idx_q   <= '0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      idx_q   <= idx_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
`ifdef UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    idx_d   = idx_q;
    tx_d    = tx_q;
    done_d  = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_d   = par_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (tx_start) begin
          state_d = START;
          sh_d    = tx_data;
          idx_d   = '0;
          tx_d    = 1'b0;
`ifdef UART_TX_PARITY_EN
          par_d   = ^tx_data;
`endif
        end
      end
      START: begin
        if (bit_tick) begin
          state_d = DATA;
          tx_d    = sh_q[0];
          sh_d    = sh_q >> 1;
        end
      end
      DATA: begin
        if (bit_tick) begin
          if (idx_q == 3'd7) begin
            idx_d = '0;
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
            tx_d    = par_q;
`else
            state_d = STOP;
            tx_d    = 1'b1;
`endif
          end else begin
            idx_d = idx_q + 3'd1;
            tx_d  = sh_q[0];
            sh_d  = sh_q >> 1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_tick) begin
          state_d = STOP;
          tx_d    = 1'b1;
        end
      end
`endif
      STOP: begin
        if (bit_tick) begin
          state_d = IDLE;
          tx_d    = 1'b1;
          done_d  = 1'b1;
        end
      end
`ifdef UART_TX_PARITY_EN
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
`endif
    endcase
  end

  assign tx      = tx_q;
  assign tx_done = done_q;
  assign tx_busy = (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: frame table, corner sequences,
// and randomized traffic against a cycle-offset reference model.
module tb_uart_tx;

  localparam int C = 4;
`ifdef UART_TX_PARITY_EN
  localparam int FR = 11;
`else
  localparam int FR = 10;
`endif

  typedef struct {
    logic [7:0]  data;
    logic [10:0] frame;
  } vec_t;

  logic       clk;
  logic       reset;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       tx_busy;
  logic       tx_done;
  logic       tx;

  int tests;
  int fails;
  int cyc;

  uart_tx #(
    .CLKS_PER_BIT(C)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .tx_data (tx_data),
    .tx_start(tx_start),
    .tx_busy (tx_busy),
    .tx_done (tx_done),
    .tx      (tx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Frame as sent on the wire, bit 0 first
  function automatic logic [10:0] frame_of(input logic [7:0] d);
    logic [10:0] f;
    f      = '0;
    f[0]   = 1'b0;
    f[8:1] = d;
`ifdef UART_TX_PARITY_EN
    f[9]   = ^d;
    f[10]  = 1'b1;
`else
    f[9]   = 1'b1;
`endif
    return f;
  endfunction

  // Reference model: frame tracked as an offset from its first cycle
  bit          armed;
  bit          m_act;
  int          m_off;
  logic [10:0] m_bits;
  logic        e_tx, e_busy, e_done;

  initial begin
    armed = 0;
    m_act = 0;
    m_off = 0;
    cyc   = 0;
  end

  always @(posedge clk) begin
    cyc++;
    e_done = 1'b0;
    if (reset) begin
      m_act  = 0;
      e_tx   = 1'b1;
      e_busy = 1'b0;
    end else begin
      if (!m_act && tx_start) begin
        m_act  = 1;
        m_off  = 0;
        m_bits = frame_of(tx_data);
      end else if (m_act) begin
        m_off++;
      end
      if (m_act && m_off < FR * C) begin
        e_tx   = m_bits[m_off / C];
        e_busy = 1'b1;
      end else if (m_act) begin
        e_tx   = 1'b1;
        e_busy = 1'b0;
        e_done = 1'b1;
        m_act  = 0;
      end else begin
        e_tx   = 1'b1;
        e_busy = 1'b0;
      end
    end
    armed = 1;
  end

  always @(negedge clk) begin
    if (armed) begin
      check("mdl_tx", 32'(tx), 32'(e_tx));
      check("mdl_busy", 32'(tx_busy), 32'(e_busy));
      check("mdl_done", 32'(tx_done), 32'(e_done));
    end
  end

  vec_t tab[6];
  int   dones;
  int   first_done;

  initial begin
    tests = 0;
    fails = 0;
`ifdef UART_TX_PARITY_EN
    tab[0] = '{8'hA5, 11'b1_0_10100101_0};
    tab[1] = '{8'h00, 11'b1_0_00000000_0};
    tab[2] = '{8'hFF, 11'b1_0_11111111_0};
    tab[3] = '{8'h3C, 11'b1_0_00111100_0};
    tab[4] = '{8'h07, 11'b1_1_00000111_0};
    tab[5] = '{8'h80, 11'b1_1_10000000_0};
`else
    tab[0] = '{8'hA5, 11'b0_1_10100101_0};
    tab[1] = '{8'h00, 11'b0_1_00000000_0};
    tab[2] = '{8'hFF, 11'b0_1_11111111_0};
    tab[3] = '{8'h3C, 11'b0_1_00111100_0};
    tab[4] = '{8'h07, 11'b0_1_00000111_0};
    tab[5] = '{8'h80, 11'b0_1_10000000_0};
`endif

    reset    = 1'b1;
    tx_start = 1'b0;
    tx_data  = 8'h00;
    step;
    step;
    reset = 1'b0;
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_busy", 32'(tx_busy), 32'd0);
    check("rst_done", 32'(tx_done), 32'd0);
    for (int i = 0; i < 10; i++) begin
      step;
      check("idle_tx", 32'(tx), 32'd1);
      check("idle_busy", 32'(tx_busy), 32'd0);
    end

    // Directed frames from the table
    for (int i = 0; i < 6; i++) begin
      tx_start = 1'b1;
      tx_data  = tab[i].data;
      step;
      tx_start = 1'b0;
      tx_data  = 8'($urandom);
      for (int k = 1; k <= FR * C; k++) begin
        check("tbl_tx", 32'(tx), 32'(tab[i].frame[(k - 1) / C]));
        check("tbl_busy", 32'(tx_busy), 32'd1);
        check("tbl_done", 32'(tx_done), 32'd0);
        step;
      end
      check("tbl_end_done", 32'(tx_done), 32'd1);
      check("tbl_end_busy", 32'(tx_busy), 32'd0);
      check("tbl_end_tx", 32'(tx), 32'd1);
      step;
      check("tbl_post_done", 32'(tx_done), 32'd0);
    end

    // Held start: data change mid-frame ignored, back-to-back retrigger
    tx_start = 1'b1;
    tx_data  = 8'h00;
    step;
    for (int k = 1; k <= FR * C + 1; k++) begin
      if (k == 5) tx_data = 8'hFF;
      if (k <= FR * C) begin
        check("held_tx", 32'(tx), 32'(tab[1].frame[(k - 1) / C]));
      end else begin
        check("held_gap_tx", 32'(tx), 32'd1);
        check("held_done", 32'(tx_done), 32'd1);
      end
      step;
    end
    check("held_restart_tx", 32'(tx), 32'd0);
    check("held_restart_busy", 32'(tx_busy), 32'd1);
    tx_start = 1'b0;
    for (int k = 0; k < C; k++) step;
    check("held_ff_bit0", 32'(tx), 32'd1);
    for (int k = 0; k < FR * C; k++) step;

    // Start pulse mid-frame is ignored
    tx_start = 1'b1;
    tx_data  = 8'hA5;
    step;
    tx_start   = 1'b0;
    dones      = 0;
    first_done = -1;
    for (int k = 1; k <= FR * C + 10; k++) begin
      if (k == 10) begin
        tx_start = 1'b1;
        tx_data  = 8'h3C;
      end else if (k == 11) begin
        tx_start = 1'b0;
      end
      if (tx_done) begin
        dones++;
        first_done = k;
      end
      step;
    end
    check("mid_done_cnt", 32'(dones), 32'd1);
    check("mid_done_cyc", 32'(first_done), 32'(FR * C + 1));

    // Reset mid-frame drops the frame without tx_done
    tx_start = 1'b1;
    tx_data  = 8'h5A;
    step;
    tx_start = 1'b0;
    for (int k = 1; k < 20; k++) step;
    reset = 1'b1;
    step;
    reset = 1'b0;
    check("rstm_tx", 32'(tx), 32'd1);
    check("rstm_busy", 32'(tx_busy), 32'd0);
    check("rstm_done", 32'(tx_done), 32'd0);
    dones = 0;
    for (int k = 0; k < 50; k++) begin
      if (tx_done) dones++;
      step;
    end
    check("rstm_no_done", 32'(dones), 32'd0);

    // Randomized traffic, checked by the model every cycle
    for (int k = 0; k < 3000; k++) begin
      tx_start = ($urandom_range(0, 7) == 0);
      tx_data  = 8'($urandom);
      reset    = ($urandom_range(0, 399) == 0);
      step;
    end
    reset    = 1'b0;
    tx_start = 1'b0;
    for (int k = 0; k < FR * C + 4; k++) step;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
